// File: rtl/load_store_unit.sv
// load_store_unit: sequences CPU loads/stores onto data port 2 of the OTTER memory.
// Macro LSU_MISALIGN_SPLIT_EN enables splitting of word-crossing accesses; without it they are rejected.
module load_store_unit #(
    parameter logic [31:0] IO_BASE = 32'h00010000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LSU_REQ,
    input  logic        LSU_WE,
    input  logic [31:0] LSU_ADDR,
    input  logic [31:0] LSU_WDATA,
    input  logic [1:0]  LSU_SIZE,
    input  logic        LSU_SIGN,
    output logic        LSU_BUSY,
    output logic        LSU_DONE,
    output logic        LSU_ERR,
    output logic [31:0] LSU_RDATA,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, ISSUE2, CAPTURE2, WRITE, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, RESP} state_t;
`endif

    state_t      state, state_next;
    logic        rden_n, we_n, sign_n, done_n, err_n;
    logic [31:0] addr_n, din_n, rdata_n;
    logic [1:0]  size_n;

    logic [2:0]  req_bytes, req_end;
    logic [31:0] req_last;
    logic        req_io, req_cross, req_err;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        cross_q, sign_q;
    logic [1:0]  off_q, size_q, last_idx_q, byte_idx_q, byte_idx_n, idx_next, req_last_idx;
    logic [31:0] wdata_q, word0_q, word0_n, merged;
`endif

    always_comb begin
        case (LSU_SIZE)
            2'd0:    req_bytes = 3'd1;
            2'd1:    req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_end   = {1'b0, LSU_ADDR[1:0]} + req_bytes;
        req_last  = LSU_ADDR + {29'd0, req_bytes} - 32'd1;
        req_io    = LSU_ADDR >= IO_BASE;
        req_cross = req_end > 3'd4;
        req_err   = (LSU_SIZE == 2'd3) || (!req_io && req_last >= IO_BASE) || (req_io && req_cross);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (req_cross) req_err = 1'b1;
`endif
    end

    assign LSU_BUSY = (state != IDLE);

    // Outputs are registered; this block computes their values for the next cycle.
    always_comb begin
        state_next = state;
        rden_n     = 1'b0;
        we_n       = 1'b0;
        addr_n     = MEM_ADDR2;
        din_n      = MEM_DIN2;
        size_n     = MEM_SIZE;
        sign_n     = MEM_SIGN;
        done_n     = 1'b0;
        err_n      = 1'b0;
        rdata_n    = LSU_RDATA;
`ifdef LSU_MISALIGN_SPLIT_EN
        byte_idx_n   = byte_idx_q;
        word0_n      = word0_q;
        idx_next     = byte_idx_q + 2'd1;
        merged       = 32'({MEM_DOUT2, word0_q} >> {off_q, 3'b000});
        if (size_q == 2'd1)
            merged = sign_q ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
        case (LSU_SIZE)
            2'd0:    req_last_idx = 2'd0;
            2'd1:    req_last_idx = 2'd1;
            default: req_last_idx = 2'd3;
        endcase
`endif
        case (state)
            IDLE: begin
                if (LSU_REQ) begin
                    rdata_n = 32'd0;
                    if (req_err) begin
                        state_next = RESP;
                        done_n     = 1'b1;
                        err_n      = 1'b1;
                    end else if (LSU_WE) begin
                        state_next = WRITE;
                        we_n       = 1'b1;
                        addr_n     = LSU_ADDR;
                        din_n      = LSU_WDATA;
                        size_n     = LSU_SIZE;
                        sign_n     = LSU_SIGN;
`ifdef LSU_MISALIGN_SPLIT_EN
                        byte_idx_n = 2'd0;
                        if (req_cross) begin
                            size_n = 2'd0;
                            din_n  = {24'd0, LSU_WDATA[7:0]};
                        end
`endif
                    end else begin
                        state_next = ISSUE;
                        rden_n     = 1'b1;
                        addr_n     = LSU_ADDR;
                        size_n     = LSU_SIZE;
                        sign_n     = LSU_SIGN;
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (req_cross) begin
                            addr_n = {LSU_ADDR[31:2], 2'b00};
                            size_n = 2'd2;
                            sign_n = 1'b0;
                        end
`endif
                    end
                end
            end
            ISSUE: state_next = CAPTURE;
            // Address/size stay put here: the memory sizes MEM_DOUT2 from the live address.
            CAPTURE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (cross_q) begin
                    state_next = ISSUE2;
                    rden_n     = 1'b1;
                    addr_n     = MEM_ADDR2 + 32'd4;
                    word0_n    = MEM_DOUT2;
                end else
`endif
                begin
                    state_next = RESP;
                    done_n     = 1'b1;
                    rdata_n    = MEM_DOUT2;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE2: state_next = CAPTURE2;
            CAPTURE2: begin
                state_next = RESP;
                done_n     = 1'b1;
                rdata_n    = merged;
            end
`endif
            WRITE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (cross_q && byte_idx_q != last_idx_q) begin
                    we_n       = 1'b1;
                    byte_idx_n = idx_next;
                    addr_n     = MEM_ADDR2 + 32'd1;
                    din_n      = {24'd0, 8'(wdata_q >> {idx_next, 3'b000})};
                end else
`endif
                begin
                    state_next = RESP;
                    done_n     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            MEM_RDEN2 <= 1'b0;
            MEM_WE2   <= 1'b0;
            MEM_ADDR2 <= 32'd0;
            MEM_DIN2  <= 32'd0;
            MEM_SIZE  <= 2'd0;
            MEM_SIGN  <= 1'b0;
            LSU_DONE  <= 1'b0;
            LSU_ERR   <= 1'b0;
            LSU_RDATA <= 32'd0;
        end else begin
            state     <= state_next;
            MEM_RDEN2 <= rden_n;
            MEM_WE2   <= we_n;
            MEM_ADDR2 <= addr_n;
            MEM_DIN2  <= din_n;
            MEM_SIZE  <= size_n;
            MEM_SIGN  <= sign_n;
            LSU_DONE  <= done_n;
            LSU_ERR   <= err_n;
            LSU_RDATA <= rdata_n;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Request fields needed after accept to merge split reads and sequence split stores.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cross_q    <= 1'b0;
            sign_q     <= 1'b0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            last_idx_q <= 2'd0;
            wdata_q    <= 32'd0;
            byte_idx_q <= 2'd0;
            word0_q    <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_n;
            word0_q    <= word0_n;
            if (state == IDLE && LSU_REQ) begin
                cross_q    <= req_cross;
                sign_q     <= LSU_SIGN;
                off_q      <= LSU_ADDR[1:0];
                size_q     <= LSU_SIZE;
                last_idx_q <= req_last_idx;
                wdata_q    <= LSU_WDATA;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench for load_store_unit with a byte-addressed OTTER memory model.
module tb_load_store_unit;
    localparam logic [31:0] IO_BASE = 32'h00010000;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        CLK, RST;
    logic        LSU_REQ, LSU_WE, LSU_SIGN;
    logic [31:0] LSU_ADDR, LSU_WDATA;
    logic [1:0]  LSU_SIZE;
    logic        LSU_BUSY, LSU_DONE, LSU_ERR;
    logic [31:0] LSU_RDATA;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.IO_BASE(IO_BASE)) dut (
        .CLK(CLK), .RST(RST),
        .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE), .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA),
        .LSU_SIZE(LSU_SIZE), .LSU_SIGN(LSU_SIGN), .LSU_BUSY(LSU_BUSY), .LSU_DONE(LSU_DONE),
        .LSU_ERR(LSU_ERR), .LSU_RDATA(LSU_RDATA), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: synchronous word read, output sized combinationally from the live address.
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] rd_word_q = 32'd0;

    function automatic logic [7:0] rdb(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge CLK) begin
        logic [31:0] w;
        int n;
        w = {MEM_ADDR2[31:2], 2'b00};
        if (MEM_RDEN2) rd_word_q <= {rdb(w + 3), rdb(w + 2), rdb(w + 1), rdb(w)};
        if (MEM_WE2) begin
            n = (MEM_SIZE == 2'd0) ? 1 : (MEM_SIZE == 2'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) mem[MEM_ADDR2 + i] = 8'(MEM_DIN2 >> (8 * i));
        end
    end

    always_comb begin
        logic [31:0] sh;
        sh = rd_word_q >> {MEM_ADDR2[1:0], 3'b000};
        case (MEM_SIZE)
            2'd0:    MEM_DOUT2 = MEM_SIGN ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    MEM_DOUT2 = MEM_SIGN ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: MEM_DOUT2 = sh;
        endcase
    end

    // Bus monitor sampled mid-cycle.
    int          rd_cnt, wr_cnt;
    logic [31:0] rd_addr_log[$], wr_addr_log[$], wr_din_log[$];
    logic [1:0]  rd_size_log[$], wr_size_log[$];

    always @(negedge CLK) begin
        if (MEM_RDEN2) begin
            rd_cnt++;
            rd_addr_log.push_back(MEM_ADDR2);
            rd_size_log.push_back(MEM_SIZE);
        end
        if (MEM_WE2) begin
            wr_cnt++;
            wr_addr_log.push_back(MEM_ADDR2);
            wr_din_log.push_back(MEM_DIN2);
            wr_size_log.push_back(MEM_SIZE);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clear_logs();
        rd_cnt = 0;
        wr_cnt = 0;
        rd_addr_log.delete();
        rd_size_log.delete();
        wr_addr_log.delete();
        wr_din_log.delete();
        wr_size_log.delete();
    endtask

    // One request; returns the cycle (1 = first after accept) in which DONE was seen.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic sign,
                                  output int cyc, output logic [31:0] rdata, output logic err);
        @(negedge CLK);
        clear_logs();
        LSU_REQ = 1'b1; LSU_WE = we; LSU_ADDR = addr; LSU_WDATA = wdata;
        LSU_SIZE = size; LSU_SIGN = sign;
        @(posedge CLK);
        #1;
        LSU_REQ = 1'b0;
        cyc = 1;
        while (!LSU_DONE && cyc < 30) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        rdata = LSU_RDATA;
        err = LSU_ERR;
        @(posedge CLK);
        #1;
        check_output($sformatf("done pulse width addr=%h", addr), {31'd0, LSU_DONE}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size,
                                logic sign, logic chk, logic [31:0] rdata, logic err,
                                int cyc, int rd, int wr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sign = sign;
        v.chk_rdata = chk; v.exp_rdata = rdata; v.exp_err = err;
        v.exp_cyc = cyc; v.exp_rd = rd; v.exp_wr = wr;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          cyc, done_cnt;
        int          done_at[3];
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_bytes[4];

        {mem[32'h100], mem[32'h101], mem[32'h102], mem[32'h103]} = 32'hBBAA9988;
        {mem[32'h200], mem[32'h201], mem[32'h202], mem[32'h203]} = 32'h11223344;
        {mem[32'h204], mem[32'h205], mem[32'h206], mem[32'h207]} = 32'h55667788;
        mem[32'h11000] = 8'h7E;

        //            we    addr          wdata         sz    sg    chk   rdata                             err    cyc           rd            wr
        vecs.push_back(mk(1'b0, 32'h100,   32'h0,        2'd2, 1'b0, 1'b1, 32'h8899AABB,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h101,   32'h0,        2'd0, 1'b0, 1'b1, 32'hFFFFFFAA,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h101,   32'h0,        2'd0, 1'b1, 1'b1, 32'h000000AA,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h102,   32'h0,        2'd1, 1'b0, 1'b1, 32'hFFFF8899,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h101,   32'h0,        2'd1, 1'b1, 1'b1, 32'h000099AA,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h203,   32'h0,        2'd1, 1'b0, 1'b1, SPLIT ? 32'h00005544 : 32'h0,    !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0, 0));
        vecs.push_back(mk(1'b0, 32'h202,   32'h0,        2'd2, 1'b1, 1'b1, SPLIT ? 32'h66554433 : 32'h0,    !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0, 0));
        vecs.push_back(mk(1'b1, 32'h400,   32'h12345678, 2'd2, 1'b0, 1'b0, 32'h0,                           1'b0,  2,            0,            1));
        vecs.push_back(mk(1'b0, 32'h400,   32'h0,        2'd2, 1'b0, 1'b1, 32'h12345678,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b1, 32'h405,   32'hFFFFFFA5, 2'd0, 1'b0, 1'b0, 32'h0,                           1'b0,  2,            0,            1));
        vecs.push_back(mk(1'b0, 32'h404,   32'h0,        2'd2, 1'b0, 1'b1, 32'h0000A500,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h11000, 32'h0,        2'd0, 1'b0, 1'b1, 32'h0000007E,                    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'hFFFF,  32'h0,        2'd1, 1'b0, 1'b1, 32'h0,                           1'b1,  1,            0,            0));
        vecs.push_back(mk(1'b0, 32'h0,     32'h0,        2'd3, 1'b0, 1'b1, 32'h0,                           1'b1,  1,            0,            0));
        vecs.push_back(mk(1'b0, 32'h11002, 32'h0,        2'd2, 1'b0, 1'b1, 32'h0,                           1'b1,  1,            0,            0));
        vecs.push_back(mk(1'b0, 32'hFFFE,  32'h0,        2'd2, 1'b0, 1'b1, 32'h0,                           1'b1,  1,            0,            0));
        vecs.push_back(mk(1'b1, 32'h301,   32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'h0,                           !SPLIT, SPLIT ? 5 : 1, 0,            SPLIT ? 4 : 0));
        vecs.push_back(mk(1'b0, 32'h300,   32'h0,        2'd2, 1'b0, 1'b1, SPLIT ? 32'hADBEEF00 : 32'h0,    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b0, 32'h304,   32'h0,        2'd2, 1'b0, 1'b1, SPLIT ? 32'h000000DE : 32'h0,    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b1, 32'h407,   32'h0000CAFE, 2'd1, 1'b0, 1'b0, 32'h0,                           !SPLIT, SPLIT ? 3 : 1, 0,            SPLIT ? 2 : 0));
        vecs.push_back(mk(1'b0, 32'h404,   32'h0,        2'd2, 1'b0, 1'b1, SPLIT ? 32'hFE00A500 : 32'h0000A500, 1'b0, 3,          1,            0));
        vecs.push_back(mk(1'b0, 32'h408,   32'h0,        2'd2, 1'b0, 1'b1, SPLIT ? 32'h000000CA : 32'h0,    1'b0,  3,            1,            0));
        vecs.push_back(mk(1'b1, 32'h11004, 32'h0000005A, 2'd0, 1'b0, 1'b0, 32'h0,                           1'b0,  2,            0,            1));

        LSU_REQ = 1'b0; LSU_WE = 1'b0; LSU_ADDR = 32'd0; LSU_WDATA = 32'd0;
        LSU_SIZE = 2'd0; LSU_SIGN = 1'b0; RST = 1'b0;
        clear_logs();
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_output("reset BUSY", {31'd0, LSU_BUSY}, 32'd0);
        check_output("reset DONE", {31'd0, LSU_DONE}, 32'd0);
        check_output("reset ERR", {31'd0, LSU_ERR}, 32'd0);
        check_output("reset RDATA", LSU_RDATA, 32'd0);
        check_output("reset RDEN2/WE2", {30'd0, MEM_RDEN2, MEM_WE2}, 32'd0);
        check_output("reset ADDR2", MEM_ADDR2, 32'd0);
        check_output("reset DIN2", MEM_DIN2, 32'd0);
        check_output("reset SIZE/SIGN", {29'd0, MEM_SIZE, MEM_SIGN}, 32'd0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, cyc, rdata, err);
            check_output($sformatf("vec%0d done cycle", i), cyc, vecs[i].exp_cyc);
            check_output($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check_output($sformatf("vec%0d rden count", i), rd_cnt, vecs[i].exp_rd);
            check_output($sformatf("vec%0d we count", i), wr_cnt, vecs[i].exp_wr);
            if (vecs[i].chk_rdata)
                check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Aligned load drives the request address and size on the read.
        apply_stimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, cyc, rdata, err);
        check_output("aligned read count", rd_addr_log.size(), 1);
        if (rd_addr_log.size() > 0) begin
            check_output("aligned read addr", rd_addr_log[0], 32'h100);
            check_output("aligned read size", {30'd0, rd_size_log[0]}, 32'd2);
        end

`ifdef LSU_MISALIGN_SPLIT_EN
        apply_stimulus(1'b0, 32'h203, 32'h0, 2'd1, 1'b0, cyc, rdata, err);
        check_output("split read count", rd_addr_log.size(), 2);
        for (int i = 0; i < 2 && i < rd_addr_log.size(); i++) begin
            check_output($sformatf("split read%0d addr", i), rd_addr_log[i], 32'h200 + 4 * i);
            check_output($sformatf("split read%0d size", i), {30'd0, rd_size_log[i]}, 32'd2);
        end

        apply_stimulus(1'b1, 32'h601, 32'hDEADBEEF, 2'd2, 1'b0, cyc, rdata, err);
        exp_bytes = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
        check_output("split store count", wr_addr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            check_output($sformatf("split store%0d addr", i), wr_addr_log[i], 32'h601 + i);
            check_output($sformatf("split store%0d byte", i), {24'd0, wr_din_log[i][7:0]}, exp_bytes[i]);
            check_output($sformatf("split store%0d size", i), {30'd0, wr_size_log[i]}, 32'd0);
        end

        // Reset in the second write cycle of a split store.
        @(negedge CLK);
        clear_logs();
        LSU_REQ = 1'b1; LSU_WE = 1'b1; LSU_ADDR = 32'h501; LSU_WDATA = 32'h11223344;
        LSU_SIZE = 2'd2; LSU_SIGN = 1'b0;
        @(posedge CLK);
        #1;
        LSU_REQ = 1'b0;
        @(posedge CLK);
        #1;
        check_output("pre-reset WE2", {31'd0, MEM_WE2}, 32'd1);
        RST = 1'b1;
        #1;
        check_output("mid reset WE2", {31'd0, MEM_WE2}, 32'd0);
        check_output("mid reset BUSY/DONE", {30'd0, LSU_BUSY, LSU_DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        check_output("mid reset bytes written", wr_cnt, 1);
        apply_stimulus(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, cyc, rdata, err);
        check_output("post reset rdata", rdata, 32'h00004400);
        check_output("post reset cycle", cyc, 3);
`else
        // Reset while a read is being issued.
        @(negedge CLK);
        clear_logs();
        LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_ADDR = 32'h100; LSU_SIZE = 2'd2; LSU_SIGN = 1'b0;
        @(posedge CLK);
        #1;
        LSU_REQ = 1'b0;
        check_output("pre-reset RDEN2", {31'd0, MEM_RDEN2}, 32'd1);
        RST = 1'b1;
        #1;
        check_output("mid reset RDEN2", {31'd0, MEM_RDEN2}, 32'd0);
        check_output("mid reset BUSY/DONE", {30'd0, LSU_BUSY, LSU_DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        apply_stimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, cyc, rdata, err);
        check_output("post reset rdata", rdata, 32'h8899AABB);
        check_output("post reset cycle", cyc, 3);
`endif

        // REQ held high: accepts only from IDLE, one DONE per accept.
        @(negedge CLK);
        clear_logs();
        LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_ADDR = 32'h100; LSU_SIZE = 2'd2; LSU_SIGN = 1'b0;
        done_cnt = 0;
        done_at = '{0, 0, 0};
        @(posedge CLK);
        #1;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin
                @(posedge CLK);
                #1;
            end
            if (LSU_DONE) begin
                if (done_cnt < 3) done_at[done_cnt] = c;
                done_cnt++;
            end
        end
        @(negedge CLK);
        LSU_REQ = 1'b0;
        @(posedge CLK);
        #1;
        check_output("held req done count", done_cnt, 3);
        check_output("held req done0", done_at[0], 3);
        check_output("held req done1", done_at[1], 7);
        check_output("held req done2", done_at[2], 11);
        check_output("held req rden count", rd_cnt, 3);
        check_output("held req idle after", {31'd0, LSU_BUSY}, 32'd0);
        check_output("held req rdata", LSU_RDATA, 32'h8899AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
